// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: ALU writes take priority, long-latency writes
// wait in a small FIFO. Flags read-after-write hazards against anything still pending.
module writeback_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 4,
  parameter int DROP_R0 = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_wr_en,
  input  logic [ADDR_W-1:0]          alu_wr_reg,
  input  logic [DATA_W-1:0]          alu_wr_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [ADDR_W-1:0]          ld_reg,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic [ADDR_W-1:0]          rd_reg1,
  input  logic [ADDR_W-1:0]          rd_reg2,
  output logic                       hazard1,
  output logic                       hazard2,
  output logic                       RegWrt,
  output logic [ADDR_W-1:0]          WirteReg,
  output logic [DATA_W-1:0]          WirteData,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam bit DROP = (DROP_R0 != 0);

  logic [ADDR_W-1:0] r_mem_reg  [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_wrt;
  logic [ADDR_W-1:0] r_wreg;
  logic [DATA_W-1:0] r_wdata;

  logic              w_alu_issue;
  logic              w_pop;
  logic              w_issue;
  logic              w_ld_ready;
  logic              w_push;
  logic              w_haz1;
  logic              w_haz2;
  logic [PTR_W-1:0]  w_idx;

  // Arbitration: a dropped r0 ALU write does not occupy the port.
  always_comb begin
    w_alu_issue = alu_wr_en && !(DROP && (alu_wr_reg == '0));
    w_pop       = !w_alu_issue && (r_count != '0);
    w_issue     = w_alu_issue || w_pop;
    w_ld_ready  = !rst && (r_count < FULL_CNT);
    w_push      = ld_valid && w_ld_ready && !(DROP && (ld_reg == '0));
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_reg[r_wr_ptr]  <= ld_reg;
      r_mem_data[r_wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output stage: index/data hold their last value when nothing issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrt   <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else begin
      r_wrt <= w_issue;
      if (w_issue) begin
        r_wreg  <= w_alu_issue ? alu_wr_reg  : r_mem_reg[r_rd_ptr];
        r_wdata <= w_alu_issue ? alu_wr_data : r_mem_data[r_rd_ptr];
      end
    end
  end

  // Only the first r_count slots from the read pointer hold live entries.
  always_comb begin
    w_haz1 = r_wrt && (r_wreg == rd_reg1);
    w_haz2 = r_wrt && (r_wreg == rd_reg2);
    w_idx  = r_rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < r_count) begin
        if (r_mem_reg[w_idx] == rd_reg1) w_haz1 = 1'b1;
        if (r_mem_reg[w_idx] == rd_reg2) w_haz2 = 1'b1;
      end
    end
    if (DROP && (rd_reg1 == '0)) w_haz1 = 1'b0;
    if (DROP && (rd_reg2 == '0)) w_haz2 = 1'b0;
  end

  assign ld_ready   = w_ld_ready;
  assign hazard1    = w_haz1;
  assign hazard2    = w_haz2;
  assign RegWrt     = r_wrt;
  assign WirteReg   = r_wreg;
  assign WirteData  = r_wdata;
  assign fifo_count = r_count;

endmodule
